// File: rtl/rv_alu_pkg.sv
// Shared types and encodings for the RV32I/RV64I integer execute unit.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: alu_op_e, FSM state enum, opcode/funct3/funct7 constants, is_shift_op().
package rv_alu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_SHIFT, ST_DONE
  } alu_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // SUB shares F3_ADD and SRA shares F3_SRL; funct7 tells them apart.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/rv_alu_seq_if.sv
// Handshake bundle between register-read, the execute unit and writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// master: drives the request and out_ready; slave: the execute unit.
interface rv_alu_seq_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );

endinterface

// File: rtl/rv_alu_decode.sv
// Maps (opcode, funct3, funct7) to an ALU operation, operand-B select and shift flag.
// Latency: purely combinational.
// Backpressure: none; also used by the hazard unit.
// Ports: opcode/funct3/funct7 in; op (alu_op_e), imm_sel (1 = immediate is operand B), is_shift out.
module rv_alu_decode
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    op,
  output logic       imm_sel,
  output logic       is_shift
);

  // On RV64 funct7[0] of a shift-immediate is shamt[5], so it is masked out of the legality check.
  logic [6:0] f7_shift;
  assign f7_shift = (XLEN == 64) ? {funct7[6:1], 1'b0} : funct7;

  always_comb begin
    op      = ILLEGAL;
    imm_sel = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  op = ADD;
            F3_SLL:  op = SLL;
            F3_SLT:  op = SLT;
            F3_SLTU: op = SLTU;
            F3_XOR:  op = XOR;
            F3_SRL:  op = SRL;
            F3_OR:   op = OR;
            F3_AND:  op = AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD) begin
            op = SUB;
          end else if (funct3 == F3_SRL) begin
            op = SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        imm_sel = 1'b1;
        case (funct3)
          F3_ADD:  op = ADD;
          F3_SLT:  op = SLT;
          F3_SLTU: op = SLTU;
          F3_XOR:  op = XOR;
          F3_OR:   op = OR;
          F3_AND:  op = AND;
          F3_SLL: begin
            if (f7_shift == F7_BASE) op = SLL;
          end
          F3_SRL: begin
            if (f7_shift == F7_BASE) begin
              op = SRL;
            end else if (f7_shift == F7_ALT) begin
              op = SRA;
            end
          end
        endcase
      end
      default: op = ILLEGAL;
    endcase
  end

  assign is_shift = is_shift_op(op);

endmodule

// File: rtl/rv_alu_seq.sv
// RV32I/RV64I integer execute unit: one-cycle logic/arith/compare, iterative shifter.
// Latency: 1 cycle; shifts by s > 0 take 1 + ceil(s / SHIFT_STEP) cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while shifting or stalled.
// Ports: clk, rst_n (async, active-low); io (slave modport): request, result, illegal, busy.
module rv_alu_seq
  import rv_alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic         clk,
  input logic         rst_n,
  rv_alu_seq_if.slave io
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  alu_state_e      state_q, state_d;
  alu_op_e         dec_op, op_q;
  logic            dec_imm_sel, dec_is_shift;
  logic [XLEN-1:0] opb, alu_res, shifted, result_q;
  logic [SHW-1:0]  shamt_in, cnt_q, cnt_next;
  logic [SHW:0]    step;
  logic            illegal_q, accept, go_shift;

  rv_alu_decode #(.XLEN(XLEN)) u_decode (
    .opcode   (io.opcode),
    .funct3   (io.funct3),
    .funct7   (io.funct7),
    .op       (dec_op),
    .imm_sel  (dec_imm_sel),
    .is_shift (dec_is_shift)
  );

  assign opb      = dec_imm_sel ? io.imm : io.rs2_val;
  assign shamt_in = opb[SHW-1:0];
  assign go_shift = dec_is_shift && (shamt_in != '0);

  // Single-cycle ops are evaluated on the incoming operands and captured at accept.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      ADD:     alu_res = io.rs1_val + opb;
      SUB:     alu_res = io.rs1_val - opb;
      SLT:     alu_res = {{(XLEN-1){1'b0}}, $signed(io.rs1_val) < $signed(opb)};
      SLTU:    alu_res = {{(XLEN-1){1'b0}}, io.rs1_val < opb};
      XOR:     alu_res = io.rs1_val ^ opb;
      OR:      alu_res = io.rs1_val | opb;
      AND:     alu_res = io.rs1_val & opb;
      default: alu_res = '0;
    endcase
  end

  // result_q doubles as the shift working register. The remaining count never
  // reaches XLEN, so when STEP == XLEN the step is always the remaining count
  // and its low SHW bits are exact.
  assign step     = ({1'b0, cnt_q} < STEP) ? {1'b0, cnt_q} : STEP;
  assign cnt_next = cnt_q - step[SHW-1:0];

  always_comb begin
    shifted = result_q;
    case (op_q)
      SLL:     shifted = result_q << step;
      SRL:     shifted = result_q >> step;
      SRA:     shifted = $signed(result_q) >>> step;
      default: shifted = result_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          accept  = 1'b1;
          state_d = go_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        io.busy = 1'b1;
        if (cnt_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        io.out_valid = 1'b1;
        io.in_ready  = io.out_ready;
        if (io.out_ready) begin
          if (io.in_valid) begin
            accept  = 1'b1;
            state_d = go_shift ? ST_SHIFT : ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= ADD;
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= dec_op;
      illegal_q <= (dec_op == ILLEGAL);
      // A shift starts from rs1; a zero-amount shift therefore completes with rs1 unchanged.
      result_q  <= dec_is_shift ? io.rs1_val : alu_res;
      cnt_q     <= dec_is_shift ? shamt_in : '0;
    end else if (state_q == ST_SHIFT) begin
      result_q  <= shifted;
      cnt_q     <= cnt_next;
    end
  end

  assign io.result  = result_q;
  assign io.illegal = illegal_q;

endmodule

// File: tb/tb_rv_alu_seq.sv
module tb_rv_alu_seq;
  import rv_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_alu_seq_if #(.XLEN(32)) bus ();
  rv_alu_seq_if #(.XLEN(64)) bus64 ();

  rv_alu_seq #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  rv_alu_seq #(.XLEN(64), .SHIFT_STEP(4)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus64)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: latency on first appearance, result/illegal on handshake.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].t_acc, sb[0].lat);
            seen = 1'b1;
          end
          if (bus.out_ready === 1'b1) begin
            e = sb.pop_front();
            chk("result", bus.result, e.res);
            chk("illegal", bus.illegal, e.ill);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : busy_mon
    forever begin
      @(negedge clk);
      #1;
      if (bus.busy === 1'b1) busy_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] er, input logic ei, input int lat, output int waited);
    exp_t e;
    @(negedge clk);
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    bus.imm      = im;
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) chk("accept_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
    e.res   = er;
    e.ill   = ei;
    e.lat   = lat;
    e.t_acc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(tag, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run64(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] im,
                       input logic [63:0] er, input int lat);
    int n;
    @(negedge clk);
    bus64.opcode   = OPC_OP_IMM;
    bus64.funct3   = f3;
    bus64.funct7   = f7;
    bus64.rs1_val  = a;
    bus64.rs2_val  = '0;
    bus64.imm      = im;
    bus64.in_valid = 1'b1;
    chk({tag, "_in_ready"}, bus64.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus64.in_valid = 1'b0;
    n = 1;
    while (bus64.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, bus64.result, er);
    chk({tag, "_ill"}, bus64.illegal, 1'b0);
  endtask

  initial begin : stim
    int w;
    int ov;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
    bus64.opcode = '0; bus64.funct3 = '0; bus64.funct7 = '0;
    bus64.rs1_val = '0; bus64.rs2_val = '0; bus64.imm = '0;

    // Reset values.
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_in_ready64", bus64.in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops, legality and zero-amount shifts.
    send(OPC_OP,     F3_ADD,  F7_BASE, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0000_0000, 1'b0, 1, w);
    send(OPC_OP,     F3_ADD,  F7_ALT,  32'd5,         32'd7, 32'h0, 32'hFFFF_FFFE, 1'b0, 1, w);
    send(OPC_OP_IMM, F3_SLT,  7'h55,   32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1, w);
    send(OPC_OP_IMM, F3_SLTU, F7_BASE, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1, w);
    send(OPC_OP_IMM, F3_AND,  7'h7F,   32'h0000_F0F0, 32'h0, 32'h0FF, 32'h0000_00F0, 1'b0, 1, w);
    send(OPC_OP,     F3_SLT,  F7_BASE, 32'hFFFF_FFFB, 32'd3, 32'h0, 32'h0000_0001, 1'b0, 1, w);
    send(OPC_OP,     F3_SLL,  F7_BASE, 32'h0000_1234, 32'd32, 32'h0, 32'h0000_1234, 1'b0, 1, w);
    send(OPC_OP,     F3_SRL,  F7_ALT,  32'h8000_0010, 32'd4, 32'h0, 32'hF800_0001, 1'b0, 5, w);
    send(OPC_OP,     F3_ADD,  7'h01,   32'd5,         32'd6, 32'h0, 32'h0, 1'b1, 1, w);
    send(OPC_OP_IMM, F3_SLL,  F7_ALT,  32'h1,         32'h0, 32'h403, 32'h0, 1'b1, 1, w);
    send(OPC_OP_IMM, F3_SRL,  7'h01,   32'h1,         32'h0, 32'h023, 32'h0, 1'b1, 1, w);
    send(7'b0110111, F3_ADD,  F7_BASE, 32'h1,         32'h1, 32'h0, 32'h0, 1'b1, 1, w);
    idle();
    drain("drain_basic");

    // Long shift, one bit per cycle.
    busy_cnt = 0;
    send(OPC_OP_IMM, F3_SRL, F7_ALT, 32'h8000_0000, 32'h0, 32'h41F, 32'hFFFF_FFFF, 1'b0, 32, w);
    idle();
    drain("drain_srai");
    chk("srai_busy_cycles", busy_cnt, 31);

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 10; i++) begin
      send(OPC_OP, F3_ADD, F7_BASE, 32'(i * 3), 32'(i + 100), 32'h0, 32'(i * 3 + i + 100), 1'b0, 1, w);
      chk("b2b_accept_wait", w, 0);
    end
    idle();
    drain("drain_b2b");

    // Output stall.
    bus.out_ready = 1'b0;
    send(OPC_OP, F3_XOR, F7_BASE, 32'h0000_AAAA, 32'h0000_5555, 32'h0, 32'h0000_FFFF, 1'b0, 1, w);
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_result", bus.result, 32'h0000_FFFF);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    drain("drain_stall");

    // Reset in the middle of a shift.
    send(OPC_OP, F3_SRL, F7_BASE, 32'hF000_0000, 32'd20, 32'h0, 32'h0000_0F00, 1'b0, 21, w);
    idle();
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ov = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov++;
    end
    chk("post_rst_no_out_valid", ov, 0);
    send(OPC_OP, F3_OR,  F7_BASE, 32'h0000_0F00, 32'h0000_00F0, 32'h0, 32'h0000_0FF0, 1'b0, 1, w);
    send(OPC_OP, F3_SRL, F7_BASE, 32'hF000_0000, 32'd4, 32'h0, 32'h0F00_0000, 1'b0, 5, w);
    idle();
    drain("drain_post_rst");

    // RV64 instance, four bits per cycle; funct7[0] carries shamt[5].
    run64("slli64_5",  F3_SLL, F7_BASE, 64'h1, 64'd5, 64'h20, 3);
    run64("srli64_63", F3_SRL, 7'h01, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 17);
    run64("srai64_40", F3_SRL, 7'h21, 64'h8000_0000_0000_0000, 64'h428, 64'hFFFF_FFFF_FF80_0000, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
